// File: rtl/ysyx22041405_rf_wport_arb.sv
// Register-file write-port arbiter: pipeline writeback has priority, MDU results queue in a FIFO.
// Optional macro YSYX22041405_RFARB_BYPASS_EN lets an MDU result skip an empty FIFO when the port is free.
module ysyx22041405_rf_wport_arb #(
    parameter int WIDTH      = 32,
    parameter int FIFO_DEPTH = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            wb_we,
    input  logic [4:0]                      wb_waddr,
    input  logic [WIDTH-1:0]                wb_wdata,
    output logic                            wb_stall,
    input  logic                            md_valid,
    output logic                            md_ready,
    input  logic [4:0]                      md_waddr,
    input  logic [WIDTH-1:0]                md_wdata,
    output logic                            rf_we,
    output logic [4:0]                      rf_waddr,
    output logic [WIDTH-1:0]                rf_wdata,
    output logic [$clog2(FIFO_DEPTH):0]     md_pending
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam int SW = $clog2(STARVE_MAX + 1);

    localparam logic [CW-1:0] DEPTH_C      = CW'(FIFO_DEPTH);
    localparam logic [SW-1:0] STARVE_MAX_C = SW'(STARVE_MAX);
    localparam logic [SW-1:0] STARVE_LAST  = SW'(STARVE_MAX - 1);

    logic [4:0]       mem_addr [FIFO_DEPTH];
    logic [WIDTH-1:0] mem_data [FIFO_DEPTH];

    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic [SW-1:0] starve_cnt;

    logic wb_req;
    logic fifo_empty;
    logic md_accept;
    logic grant_wb;
    logic pop;
    logic push;
    logic bypass;

    assign wb_req     = wb_we && (wb_waddr != 5'd0);
    assign fifo_empty = (count == '0);
    assign md_ready   = !rst && (count < DEPTH_C);
    assign md_accept  = md_valid && md_ready;
    assign grant_wb   = wb_req && !wb_stall;
    assign pop        = !grant_wb && !fifo_empty;
    assign md_pending = count;

`ifdef YSYX22041405_RFARB_BYPASS_EN
    assign bypass = !grant_wb && fifo_empty && md_accept && (md_waddr != 5'd0);
`else
    assign bypass = 1'b0;
`endif

    // x0 results complete the handshake but are dropped here
    assign push = md_accept && (md_waddr != 5'd0) && !bypass;

    always_comb begin
        rf_we    = 1'b0;
        rf_waddr = 5'd0;
        rf_wdata = '0;
        if (!rst) begin
            if (grant_wb) begin
                rf_we    = 1'b1;
                rf_waddr = wb_waddr;
                rf_wdata = wb_wdata;
            end else if (pop) begin
                rf_we    = 1'b1;
                rf_waddr = mem_addr[rd_ptr];
                rf_wdata = mem_data[rd_ptr];
            end else if (bypass) begin
                rf_we    = 1'b1;
                rf_waddr = md_waddr;
                rf_wdata = md_wdata;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_addr[wr_ptr] <= md_waddr;
            mem_data[wr_ptr] <= md_wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push && !pop) begin
                count <= count + 1'b1;
            end else if (pop && !push) begin
                count <= count - 1'b1;
            end
        end
    end

    // A stall lands exactly when the head has waited STARVE_MAX cycles, and never twice in a row
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            starve_cnt <= '0;
            wb_stall   <= 1'b0;
        end else begin
            if (pop || fifo_empty) begin
                starve_cnt <= '0;
            end else if (starve_cnt != STARVE_MAX_C) begin
                starve_cnt <= starve_cnt + 1'b1;
            end
            wb_stall <= (starve_cnt == STARVE_LAST) && !fifo_empty && !pop && !wb_stall;
        end
    end

endmodule

// File: tb/tb_ysyx22041405_rf_wport_arb.sv
// Randomized self-checking bench for ysyx22041405_rf_wport_arb against a queue-based reference model.
module tb_ysyx22041405_rf_wport_arb;

    localparam int W     = 32;
    localparam int DEPTH = 2;
    localparam int SMAX  = 4;

    typedef struct packed {
        logic [4:0]   addr;
        logic [W-1:0] data;
    } entry_t;

    logic                      clk = 1'b0;
    logic                      rst;
    logic                      wb_we;
    logic [4:0]                wb_waddr;
    logic [W-1:0]              wb_wdata;
    logic                      wb_stall;
    logic                      md_valid;
    logic                      md_ready;
    logic [4:0]                md_waddr;
    logic [W-1:0]              md_wdata;
    logic                      rf_we;
    logic [4:0]                rf_waddr;
    logic [W-1:0]              rf_wdata;
    logic [$clog2(DEPTH):0]    md_pending;

    entry_t modelQ[$];
    int     modelStarve;
    bit     modelStall;
    bit     lastAccept;

    int compareCount  = 0;
    int mismatchCount = 0;

    ysyx22041405_rf_wport_arb #(
        .WIDTH(W),
        .FIFO_DEPTH(DEPTH),
        .STARVE_MAX(SMAX)
    ) dut (
        .clk(clk),
        .rst(rst),
        .wb_we(wb_we),
        .wb_waddr(wb_waddr),
        .wb_wdata(wb_wdata),
        .wb_stall(wb_stall),
        .md_valid(md_valid),
        .md_ready(md_ready),
        .md_waddr(md_waddr),
        .md_wdata(md_wdata),
        .rf_we(rf_we),
        .rf_waddr(rf_waddr),
        .rf_wdata(rf_wdata),
        .md_pending(md_pending)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        compareCount++;
        if (observed !== expected) begin
            mismatchCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Called at posedge+1: drive one cycle, compare at the falling edge, advance the model, move to next posedge+1
    task automatic applyStimulus(input logic we, input logic [4:0] wa, input logic [W-1:0] wd,
                                 input logic mv, input logic [4:0] ma, input logic [W-1:0] md);
        bit           wbReq, grantWb, readyM, acceptM, popM, bypassM, nextStall;
        logic         expWe;
        logic [4:0]   expAddr;
        logic [W-1:0] expData;
        entry_t       newEntry;

        wb_we    = we;
        wb_waddr = wa;
        wb_wdata = wd;
        md_valid = mv;
        md_waddr = ma;
        md_wdata = md;
        #4;

        wbReq   = we && (wa != 5'd0);
        grantWb = wbReq && !modelStall;
        readyM  = modelQ.size() < DEPTH;
        acceptM = mv && readyM;
        popM    = !grantWb && (modelQ.size() != 0);
        bypassM = 1'b0;
`ifdef YSYX22041405_RFARB_BYPASS_EN
        bypassM = !grantWb && (modelQ.size() == 0) && acceptM && (ma != 5'd0);
`endif
        expWe = 1'b0; expAddr = 5'd0; expData = '0;
        if (grantWb) begin
            expWe = 1'b1; expAddr = wa; expData = wd;
        end else if (popM) begin
            expWe = 1'b1; expAddr = modelQ[0].addr; expData = modelQ[0].data;
        end else if (bypassM) begin
            expWe = 1'b1; expAddr = ma; expData = md;
        end

        checkOutput("rf_we", 64'(rf_we), 64'(expWe));
        checkOutput("rf_waddr", 64'(rf_waddr), 64'(expAddr));
        checkOutput("rf_wdata", 64'(rf_wdata), 64'(expData));
        checkOutput("md_ready", 64'(md_ready), 64'(readyM));
        checkOutput("wb_stall", 64'(wb_stall), 64'(modelStall));
        checkOutput("md_pending", 64'(md_pending), 64'(modelQ.size()));

        nextStall = (modelStarve == SMAX - 1) && (modelQ.size() != 0) && !popM && !modelStall;
        if (popM || modelQ.size() == 0) modelStarve = 0;
        else if (modelStarve < SMAX) modelStarve = modelStarve + 1;
        modelStall = nextStall;
        if (popM) void'(modelQ.pop_front());
        if (acceptM && ma != 5'd0 && !bypassM) begin
            newEntry.addr = ma;
            newEntry.data = md;
            modelQ.push_back(newEntry);
        end
        lastAccept = acceptM;

        @(posedge clk);
        #1;
    endtask

    // Asynchronous reset raised mid-cycle with live requests on the inputs
    task automatic resetDut();
        wb_we    = 1'b1;
        wb_waddr = 5'd5;
        md_valid = 1'b1;
        md_waddr = 5'd3;
        rst      = 1'b1;
        #1;
        checkOutput("rst_md_pending", 64'(md_pending), 64'd0);
        checkOutput("rst_rf_we", 64'(rf_we), 64'd0);
        checkOutput("rst_md_ready", 64'(md_ready), 64'd0);
        checkOutput("rst_wb_stall", 64'(wb_stall), 64'd0);
        modelQ.delete();
        modelStarve = 0;
        modelStall  = 1'b0;
        lastAccept  = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        checkOutput("post_rst_md_ready", 64'(md_ready), 64'd1);
    endtask

    initial begin
        bit           mvR;
        logic [4:0]   maR;
        logic [W-1:0] mdR;

        rst = 1'b1;
        wb_we = 1'b0; wb_waddr = '0; wb_wdata = '0;
        md_valid = 1'b0; md_waddr = '0; md_wdata = '0;
        modelStarve = 0; modelStall = 1'b0; lastAccept = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        checkOutput("init_md_ready", 64'(md_ready), 64'd1);

        $display("[TB] directed: pass-through and x0");
        applyStimulus(1'b1, 5'd5, 32'h12345678, 1'b0, 5'd0, '0);
        applyStimulus(1'b1, 5'd0, 32'hDEADBEEF, 1'b0, 5'd0, '0);
        applyStimulus(1'b0, 5'd0, '0, 1'b1, 5'd0, 32'h55);
        applyStimulus(1'b0, 5'd0, '0, 1'b0, 5'd0, '0);

        $display("[TB] directed: FIFO path");
        applyStimulus(1'b0, 5'd0, '0, 1'b1, 5'd7, 32'hAA);
        applyStimulus(1'b0, 5'd0, '0, 1'b0, 5'd0, '0);
        applyStimulus(1'b0, 5'd0, '0, 1'b0, 5'd0, '0);

        $display("[TB] directed: starvation");
        applyStimulus(1'b1, 5'd3, 32'h100, 1'b1, 5'd9, 32'hBEEF);
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b1, 5'(4 + i), W'(32'h200 + i), 1'b0, 5'd0, '0);
        end

        $display("[TB] directed: full then wrap");
        applyStimulus(1'b1, 5'd1, 32'h1, 1'b1, 5'd10, 32'hA0);
        applyStimulus(1'b1, 5'd2, 32'h2, 1'b1, 5'd11, 32'hA1);
        applyStimulus(1'b1, 5'd3, 32'h3, 1'b1, 5'd12, 32'hA2);
        for (int i = 0; i < 6; i++) begin
            applyStimulus(1'b0, 5'd0, '0, 1'b1, 5'(13 + i), W'(32'hB0 + i));
        end
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 5'd0, '0, 1'b0, 5'd0, '0);
        end

        $display("[TB] directed: reset with two entries queued");
        applyStimulus(1'b1, 5'd1, 32'h11, 1'b1, 5'd20, 32'hC0);
        applyStimulus(1'b1, 5'd2, 32'h22, 1'b1, 5'd21, 32'hC1);
        checkOutput("prereset_md_pending", 64'(md_pending), 64'd2);
        resetDut();

        $display("[TB] random stimulus");
        mvR = 1'b0; maR = '0; mdR = '0;
        for (int i = 0; i < 600; i++) begin
            if (i == 300) begin
                resetDut();
                mvR = 1'b0;
                lastAccept = 1'b0;
            end
            if (!(mvR && !lastAccept)) begin
                mvR = ($urandom_range(0, 2) != 0);
                maR = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
                mdR = $urandom;
            end
            applyStimulus(($urandom_range(0, 9) < 6),
                          ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31)),
                          $urandom, mvR, maR, mdR);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
        $finish;
    end

endmodule

// File: doc/ysyx22041405_rf_wport_arb.md
# ysyx22041405_rf_wport_arb

Arbiter for the single register-file write port behind the writeback stage. It shares the port between the in-order pipeline writeback (highest priority, no backpressure) and a long-latency multiply/divide unit (MDU) whose results are buffered in a small FIFO. The pipeline normally owns the port. A starvation counter forces a one-cycle writeback stall so buffered MDU results always drain.

## Interface
- `WIDTH`, 32: data width of register-file writes.
- `FIFO_DEPTH`, 2: MDU result buffer entries; must be a power of two, at least 2.
- `STARVE_MAX`, 4: cycles a non-empty FIFO may wait without a pop before `wb_stall` is raised.

- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `wb_we`  in  1  pipeline writeback request.
- `wb_waddr`  in  5  pipeline destination register.
- `wb_wdata`  in  WIDTH  pipeline write data.
- `wb_stall`  out  1  registered; holds the writeback stage this cycle, and its request is not granted.
- `md_valid`  in  1  MDU result valid.
- `md_ready`  out  1  arbiter can accept an MDU result.
- `md_waddr`  in  5  MDU destination register.
- `md_wdata`  in  WIDTH  MDU result.
- `rf_we`  out  1  register-file write enable.
- `rf_waddr`  out  5  register-file write address.
- `rf_wdata`  out  WIDTH  register-file write data.
- `md_pending`  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.

## Operation
- **Pipeline request.** `wb_req = wb_we && wb_waddr != 0`. A write to x0 counts as no request.
- **MDU accept.** An MDU result is accepted when `md_valid && md_ready`.
  - `md_ready = !rst && count < FIFO_DEPTH`. It is computed from the registered count, with no credit for a same-cycle pop.
  - A result with `md_waddr == 0` is accepted and discarded; it is never stored.
- **Grant priority.** Evaluated in this order each cycle:
  1. `wb_req && !wb_stall`: pipeline wins, and `rf_*` carries the `wb_*` values.
  2. Otherwise, if the FIFO is non-empty: pop the head, and `rf_*` carries the head entry.
  3. Otherwise `rf_we = 0`. `rf_waddr` and `rf_wdata` are don't-care, driven 0.
- **Port outputs.** `rf_we`, `rf_waddr` and `rf_wdata` are combinational. `rf_we` is forced to 0 while `rst` is high.
- **Starvation counter `starve_cnt`.**
  - Cleared on any pop and whenever the FIFO is empty.
  - Otherwise increments, saturating at `STARVE_MAX`.
- **Stall generation.** `wb_stall` is registered.
  - Next value is 1 when `starve_cnt == STARVE_MAX - 1`, the FIFO is non-empty, no pop occurs this cycle, and `wb_stall` is currently 0.
  - Otherwise the next value is 0.
  - Consequently `wb_stall` is never high two consecutive cycles, and the stalled cycle always pops.
- **FIFO.** Circular buffer with read and write pointers that wrap modulo `FIFO_DEPTH`.
  - Push and pop in the same cycle are legal at any occupancy where `md_ready = 1`; the count is unchanged.
- **Ordering (out of scope).** The issue logic guarantees no WAW conflict between an in-flight MDU result and a younger pipeline write. The arbiter does not reorder or check for this.

## Timing
- **Pipeline write latency.** 0 cycles, combinational from `wb_*` to `rf_*`.
- **MDU write latency.** The earliest write is the cycle after acceptance (FIFO path). See Configuration for the bypass case.
- **Worst-case FIFO head wait.** `STARVE_MAX + 1` cycles from reaching the head to being written.
- **Reset.** Asynchronous and takes effect immediately:
  - FIFO emptied, pointers 0, `md_pending = 0`, `starve_cnt = 0`, `wb_stall = 0`.
  - `rf_we = 0`, `md_ready = 0`.
  - Entries in flight mid-operation are lost. Upstream flushes on the same reset.
- **After reset release.** The first edge after `rst` falls is the first operational edge.
- **Edge cases.**
  - Full FIFO: `md_ready = 0`, and the MDU holds its data.
  - Empty FIFO with no `wb_req`: port idle.

## Configuration
- `YSYX22041405_RFARB_BYPASS_EN`
  - **Defined:** when the FIFO is empty, there is no grant to the pipeline, and an accepted MDU result has `md_waddr != 0`, the result is written to `rf_*` in the same cycle and not enqueued. MDU latency becomes 0 in that case.
  - **Undefined:** every MDU result passes through the FIFO, with a minimum latency of 1 cycle.

## Test plan
- **Reset values:** Assert `rst` mid-stream with FIFO count 2 -> immediately `md_pending = 0`, `rf_we = 0`, `md_ready = 0`, `wb_stall = 0`. After release, `md_ready = 1`.
- **Pipeline pass-through:** `wb_we = 1`, `wb_waddr = 5`, `wb_wdata = 0x12345678` -> same cycle `rf_we = 1`, `rf_waddr = 5`, `rf_wdata = 0x12345678`.
- **x0 writes:** `wb_waddr = 0`, `wb_we = 1` -> `rf_we = 0`. MDU result with `md_waddr = 0` -> handshake completes and `md_pending` stays 0.
- **FIFO path (bypass off):** MDU result `{x7, 0xAA}` with the pipeline idle -> `md_pending = 1` next cycle, `rf_we = 1`, `rf_waddr = 7`, `rf_wdata = 0xAA`, then `md_pending = 0`.
- **Starvation:** Pipeline writes every cycle with one MDU entry queued and `STARVE_MAX = 4` -> `wb_stall` high for exactly one cycle, 4 cycles after enqueue. In that cycle the MDU entry is written; the pipeline write follows the next cycle.
- **Full and wrap:** Fill 2 entries -> `md_ready = 0`. Then alternate pop and push across 6 results -> all 6 written in acceptance order, with pointer wrap exercised.
